ascon_p_iter: RTL

Iterative Ascon permutation engine that applies p^a to a 320-bit state, one round per clock (two with the unroll option). It schedules the 16-entry constant-addition index (0x0–0xF, constant 0x3C…0x4B), the 5-bit substitution layer and the linear diffusion layer. It runs the round index from 16−a up to 15. It sits between the mode controller (initialization, absorb, finalize) and the state register file, using a valid/ready handshake on both sides.

---
 rtl/ascon_p_iter_pkg.sv | 36 +++
 rtl/ascon_p_iter_if.sv | 21 ++
 rtl/ascon_p_iter_round.sv | 37 +++
 rtl/ascon_p_iter.sv | 87 ++++++++
 4 files changed

// File: rtl/ascon_p_iter_pkg.sv
// ascon_p_iter_pkg: shared types, FSM encoding, round constant and rotation amounts for the Ascon permutation
package ascon_pkg;

    typedef struct packed {
        logic [63:0] x0;
        logic [63:0] x1;
        logic [63:0] x2;
        logic [63:0] x3;
        logic [63:0] x4;
    } ascon_state_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    localparam int ROT_X0A = 19;
    localparam int ROT_X0B = 28;
    localparam int ROT_X1A = 61;
    localparam int ROT_X1B = 39;
    localparam int ROT_X2A = 1;
    localparam int ROT_X2B = 6;
    localparam int ROT_X3A = 10;
    localparam int ROT_X3B = 17;
    localparam int ROT_X4A = 7;
    localparam int ROT_X4B = 41;

    // idx is offset by 4 from the Ascon round number, so idx 15 carries the final constant 0x4B and idx 0 carries 0x3C
    function automatic logic [7:0] round_const(input logic [3:0] idx);
        logic [3:0] r;
        r = idx + 4'd12;
        return {~r, r};
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

endpackage

// File: rtl/ascon_p_iter_if.sv
// ascon_p_iter_if: valid/ready request and response channels of the permutation engine
interface ascon_p_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [319:0] in_state;
    logic [3:0]   in_rounds;
    logic         out_valid;
    logic         out_ready;
    logic [319:0] out_state;
    logic         busy;

    modport master (
        output in_valid, in_state, in_rounds, out_ready,
        input  in_ready, out_valid, out_state, busy
    );

    modport slave (
        input  in_valid, in_state, in_rounds, out_ready,
        output in_ready, out_valid, out_state, busy
    );
endinterface

// File: rtl/ascon_p_iter_round.sv
// ascon_round: one combinational Ascon round (constant addition, bit-sliced S-box, linear layer)
module ascon_round
    import ascon_pkg::*;
(
    input  ascon_state_t state,
    input  logic [3:0]   idx,
    output ascon_state_t result
);
    logic [63:0] a0, a1, a2, a3, a4;
    logic [63:0] b0, b1, b2, b3, b4;
    logic [63:0] s0, s1, s2, s3, s4;

    // S-box input mixing, with the round constant folded into x2
    assign a0 = state.x0 ^ state.x4;
    assign a1 = state.x1;
    assign a2 = state.x2 ^ {56'd0, round_const(idx)} ^ state.x1;
    assign a3 = state.x3;
    assign a4 = state.x4 ^ state.x3;

    assign b0 = a0 ^ (~a1 & a2);
    assign b1 = a1 ^ (~a2 & a3);
    assign b2 = a2 ^ (~a3 & a4);
    assign b3 = a3 ^ (~a4 & a0);
    assign b4 = a4 ^ (~a0 & a1);

    assign s0 = b0 ^ b4;
    assign s1 = b1 ^ b0;
    assign s2 = ~b2;
    assign s3 = b3 ^ b2;
    assign s4 = b4;

    assign result.x0 = s0 ^ rotr(s0, ROT_X0A) ^ rotr(s0, ROT_X0B);
    assign result.x1 = s1 ^ rotr(s1, ROT_X1A) ^ rotr(s1, ROT_X1B);
    assign result.x2 = s2 ^ rotr(s2, ROT_X2A) ^ rotr(s2, ROT_X2B);
    assign result.x3 = s3 ^ rotr(s3, ROT_X3A) ^ rotr(s3, ROT_X3B);
    assign result.x4 = s4 ^ rotr(s4, ROT_X4A) ^ rotr(s4, ROT_X4B);
endmodule

// File: rtl/ascon_p_iter.sv
// ascon_p_iter: iterative Ascon p^a engine, one round per clock or two when ASCON_P_UNROLL2_EN is defined
module ascon_p_iter
    import ascon_pkg::*;
#(
    parameter int ROUNDS_MAX = 12
) (
    input logic clk,
    input logic rst_n,
    ascon_p_iter_if.slave bus
);
    fsm_t         fsm;
    ascon_state_t st;
    ascon_state_t r0;
    ascon_state_t nxt;
    logic [3:0]   idx;
    logic [3:0]   step;
    logic [4:0]   rounds;
    logic         last;
    logic         in_ready;
    logic         out_valid;
    logic         busy;

    assign rounds = ({1'b0, bus.in_rounds} > 5'(ROUNDS_MAX)) ? 5'(ROUNDS_MAX) : {1'b0, bus.in_rounds};

    ascon_round u_round0 (.state(st), .idx(idx), .result(r0));

`ifdef ASCON_P_UNROLL2_EN
    ascon_state_t r1;
    logic [3:0]   idx1;
    assign idx1 = idx + 4'd1;
    ascon_round u_round1 (.state(r0), .idx(idx1), .result(r1));
    // an odd round count ends on idx 15, where the second round is bypassed
    assign nxt  = (idx == 4'd15) ? r0 : r1;
    assign last = idx >= 4'd14;
    assign step = 4'd2;
`else
    assign nxt  = r0;
    assign last = idx == 4'd15;
    assign step = 4'd1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm       <= IDLE;
            st        <= '0;
            idx       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (fsm)
                IDLE: if (bus.in_valid) begin
                    st       <= bus.in_state;
                    idx      <= 4'(5'd16 - rounds);
                    in_ready <= 1'b0;
                    if (rounds == 5'd0) begin
                        fsm       <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        fsm  <= RUN;
                        busy <= 1'b1;
                    end
                end
                RUN: begin
                    st  <= nxt;
                    idx <= last ? idx : idx + step;
                    if (last) begin
                        fsm       <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                DONE: if (bus.out_ready) begin
                    fsm       <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.busy      = busy;
    assign bus.out_state = st;
endmodule
